// File: rtl/neander_pkg.sv
// neander_pkg: shared definitions for the Neander datapath.
// Holds the program-counter operation encodings driven on pc_stack_seq.sel.
package neander_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,  // q unchanged
    PC_INC  = 3'd1,  // q + 1
    PC_LOAD = 3'd2,  // q <= d
    PC_CALL = 3'd3,  // push q + 1, q <= d
    PC_RET  = 3'd4,  // pop into q
    PC_VEC  = 3'd5,  // q <= RESET_VEC
    PC_REL  = 3'd6,  // q + signed d (optional), else hold
    PC_RSVD = 3'd7   // reserved, hold
  } pc_mode_e;

  // Stack-pointer width able to count 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: DEPTH x WIDTH LIFO holding CALL return addresses.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset (sp <= 0)
//   i_push, i_pop    push i_push_data / discard top entry (mutually exclusive)
//   i_push_data      value to push
//   o_top            entry at sp-1 (meaningless while o_empty)
//   o_empty, o_full  sp == 0 / sp == DEPTH
// A push while full or a pop while empty is ignored.
module pc_ret_stack
  import neander_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned SPW = sp_width(DEPTH);

  // Storage is sized to the full sp range so every index is in bounds;
  // entries at DEPTH and above are never written.
  logic [WIDTH-1:0] r_mem [2**SPW];
  logic [SPW-1:0]   r_sp;
  logic [SPW-1:0]   w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_sp == '0);
  assign o_full    = (r_sp == SPW'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_top_idx = r_sp - SPW'(1);
  assign o_top     = r_mem[w_top_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_do_push) begin
      r_mem[r_sp] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_stack_seq.sv
// pc_stack_seq: WIDTH-bit program counter with return-address stack.
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset (q <= RESET_VEC, stack emptied, err cleared)
//   d            jump target / relative offset from the memory data bus
//   sel          operation select (neander_pkg::pc_mode_e)
//   en           advance enable; 0 freezes all state
//   q            current PC (registered)
//   stack_empty  return stack holds no entries
//   stack_full   return stack holds DEPTH entries
//   stack_err    sticky overflow/underflow flag, cleared only by reset
// Build option: define PC_REL_BRANCH_EN to make sel = PC_REL add a signed
// offset to q; otherwise PC_REL holds.
module pc_stack_seq
  import neander_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  pc_mode_e         w_mode;
  logic [WIDTH-1:0] r_q;
  logic             r_err;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic             w_empty;
  logic             w_full;

  assign w_mode = pc_mode_e'(sel);
  assign w_inc  = r_q + WIDTH'(1);

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_inc),
    .o_top       (w_top),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  always_comb begin
    w_q_next  = r_q;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (en) begin
      case (w_mode)
        PC_INC:  w_q_next = w_inc;
        PC_LOAD: w_q_next = d;
        PC_CALL: begin
          // Overflow suppresses both the push and the jump.
          if (w_full) begin
            w_err_set = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_q_next = d;
          end
        end
        PC_RET: begin
          if (w_empty) begin
            w_err_set = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_q_next = w_top;
          end
        end
        PC_VEC:  w_q_next = RESET_VEC;
`ifdef PC_REL_BRANCH_EN
        // d is already WIDTH bits, so its sign extension is the identity
        // under modulo-2^WIDTH addition.
        PC_REL:  w_q_next = r_q + d;
`endif
        default: w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q   <= RESET_VEC;
      r_err <= 1'b0;
    end else begin
      r_q <= w_q_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign q           = r_q;
  assign stack_empty = w_empty;
  assign stack_full  = w_full;
  assign stack_err   = r_err;

endmodule

// File: tb/tb_pc_stack_seq.sv
// tb_pc_stack_seq: directed self-checking bench for pc_stack_seq
// (WIDTH=8, DEPTH=4, RESET_VEC=0). Flags are checked as {empty, full, err}.
module tb_pc_stack_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d     = '0;
  logic [2:0] sel   = '0;
  logic       en    = 1'b0;
  logic [7:0] q;
  logic       stack_empty;
  logic       stack_full;
  logic       stack_err;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, LOAD = 3'd2, CALL = 3'd3,
                         RET  = 3'd4, VEC = 3'd5, REL  = 3'd6, RSVD = 3'd7;

  pc_stack_seq #(
    .WIDTH     (8),
    .DEPTH     (4),
    .RESET_VEC (8'h00)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .d           (d),
    .sel         (sel),
    .en          (en),
    .q           (q),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  // Apply one operation for one clock edge, then settle away from the edge.
  task automatic step(input logic [2:0] s, input logic [7:0] dv, input logic e, input logic r);
    sel   = s;
    d     = dv;
    en    = e;
    reset = r;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_q, input logic [2:0] exp_f);
    checks++;
    assert (q === exp_q) else begin
      errors++;
      $error("FAIL %s q: got %h expected %h", tag, q, exp_q);
    end
    checks++;
    assert ({stack_empty, stack_full, stack_err} === exp_f) else begin
      errors++;
      $error("FAIL %s flags(e,f,err): got %b expected %b", tag,
             {stack_empty, stack_full, stack_err}, exp_f);
    end
  endtask

  initial begin
    step(HOLD, 8'h00, 1'b1, 1'b1);
    step(HOLD, 8'h00, 1'b1, 1'b1);
    chk("reset", 8'h00, 3'b100);
    reset = 1'b0;

    step(INC, 8'h00, 1'b1, 1'b0); chk("inc1", 8'h01, 3'b100);
    step(INC, 8'h00, 1'b1, 1'b0); chk("inc2", 8'h02, 3'b100);
    step(INC, 8'h00, 1'b1, 1'b0); chk("inc3", 8'h03, 3'b100);
    step(LOAD, 8'hFF, 1'b1, 1'b0); chk("load_ff", 8'hFF, 3'b100);
    step(INC, 8'h00, 1'b1, 1'b0); chk("inc_wrap", 8'h00, 3'b100);

    step(LOAD, 8'h80, 1'b1, 1'b0); chk("load_80", 8'h80, 3'b100);
    step(INC, 8'h00, 1'b0, 1'b0); chk("stall1", 8'h80, 3'b100);
    step(INC, 8'h00, 1'b0, 1'b0); chk("stall2", 8'h80, 3'b100);
    step(CALL, 8'h33, 1'b0, 1'b0); chk("stall_call", 8'h80, 3'b100);
    step(RET, 8'h00, 1'b0, 1'b0); chk("stall_ret", 8'h80, 3'b100);
    step(INC, 8'h00, 1'b1, 1'b0); chk("inc_after_stall", 8'h81, 3'b100);

    step(LOAD, 8'h10, 1'b1, 1'b0); chk("load_10", 8'h10, 3'b100);
    step(CALL, 8'h40, 1'b1, 1'b0); chk("call_40", 8'h40, 3'b000);
    step(CALL, 8'h60, 1'b1, 1'b0); chk("call_60", 8'h60, 3'b000);
    step(RET, 8'h00, 1'b1, 1'b0); chk("ret_41", 8'h41, 3'b000);
    step(RET, 8'h00, 1'b1, 1'b0); chk("ret_11", 8'h11, 3'b100);

    step(CALL, 8'hA0, 1'b1, 1'b0); chk("fill1", 8'hA0, 3'b000);
    step(CALL, 8'hB0, 1'b1, 1'b0); chk("fill2", 8'hB0, 3'b000);
    step(CALL, 8'hC0, 1'b1, 1'b0); chk("fill3", 8'hC0, 3'b000);
    step(CALL, 8'hD0, 1'b1, 1'b0); chk("fill4", 8'hD0, 3'b010);
    step(CALL, 8'hAA, 1'b1, 1'b0); chk("overflow", 8'hD0, 3'b011);
    step(RET, 8'h00, 1'b1, 1'b0); chk("pop_c1", 8'hC1, 3'b001);
    step(RET, 8'h00, 1'b1, 1'b0); chk("pop_b1", 8'hB1, 3'b001);
    step(RET, 8'h00, 1'b1, 1'b0); chk("pop_a1", 8'hA1, 3'b001);
    step(RET, 8'h00, 1'b1, 1'b0); chk("pop_12", 8'h12, 3'b101);
    step(RET, 8'h00, 1'b1, 1'b0); chk("underflow_sticky", 8'h12, 3'b101);
    step(VEC, 8'h77, 1'b1, 1'b0); chk("vec", 8'h00, 3'b101);

    step(HOLD, 8'h00, 1'b1, 1'b1); chk("reset_clears_err", 8'h00, 3'b100);
    step(RET, 8'h00, 1'b1, 1'b0); chk("ret_empty", 8'h00, 3'b101);
    step(HOLD, 8'h00, 1'b1, 1'b1); chk("reset2", 8'h00, 3'b100);

    step(LOAD, 8'h30, 1'b1, 1'b0); chk("load_30", 8'h30, 3'b100);
    step(CALL, 8'h55, 1'b1, 1'b1); chk("reset_vs_call", 8'h00, 3'b100);
    step(RET, 8'h00, 1'b1, 1'b0); chk("no_push_on_reset", 8'h00, 3'b101);
    step(HOLD, 8'h00, 1'b1, 1'b1); chk("reset3", 8'h00, 3'b100);

    step(LOAD, 8'h20, 1'b1, 1'b0); chk("load_20", 8'h20, 3'b100);
`ifdef PC_REL_BRANCH_EN
    step(REL, 8'hFE, 1'b1, 1'b0); chk("rel_minus2", 8'h1E, 3'b100);
    step(REL, 8'h05, 1'b1, 1'b0); chk("rel_plus5", 8'h23, 3'b100);
    step(RSVD, 8'h05, 1'b1, 1'b0); chk("reserved_hold", 8'h23, 3'b100);
`else
    step(REL, 8'hFE, 1'b1, 1'b0); chk("rel_hold1", 8'h20, 3'b100);
    step(REL, 8'h05, 1'b1, 1'b0); chk("rel_hold2", 8'h20, 3'b100);
    step(RSVD, 8'h05, 1'b1, 1'b0); chk("reserved_hold", 8'h20, 3'b100);
`endif
    step(HOLD, 8'h99, 1'b1, 1'b0);
`ifdef PC_REL_BRANCH_EN
    chk("hold", 8'h23, 3'b100);
`else
    chk("hold", 8'h20, 3'b100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_seq.md
Name: pc_stack_seq

Overview:
Parametrised program counter for the next-generation Neander datapath.
- Generalises the fixed 8-bit PC (hold / increment / load-from-memory) to WIDTH bits.
- Adds a hardware return-address stack for CALL/RET, a programmable reset vector, a stall enable and sticky stack-error reporting.
- Sits between the memory data bus (jump target source) and the address mux feeding REM.

Parameters:
- WIDTH, 8, PC and address width in bits (≥4).
- DEPTH, 4, return-stack entries (≥1).
- RESET_VEC, 0, PC value loaded on reset and by mode VEC.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- d  in  WIDTH  target address from the memory data bus.
- sel  in  3  operation select (encodings below).
- en  in  1  advance enable; 0 = full stall.
- q  out  WIDTH  current PC.
- stack_empty  out  1  return stack holds 0 entries.
- stack_full  out  1  return stack holds DEPTH entries.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything else. On reset:
  - q = RESET_VEC, sp = 0
  - stack_empty = 1, stack_full = 0, stack_err = 0
  - stack contents don't-care
- When en = 0 nothing changes (q, sp, stack, err), whatever sel is.
- When en = 1, sel is sampled on the clock edge. The result is visible on q one cycle later; there is no combinational path from sel or d to q.
  - 0 HOLD: q unchanged.
  - 1 INC: q <= q + 1, modulo 2^WIDTH (all-ones wraps to 0, no flag).
  - 2 LOAD: q <= d.
  - 3 CALL: push (q + 1) mod 2^WIDTH into stack[sp]; sp <= sp + 1; q <= d.
  - 4 RET: sp <= sp − 1; q <= stack[sp − 1].
  - 5 VEC: q <= RESET_VEC; stack untouched.
  - 6 REL: see Optional Feature; otherwise treated as HOLD.
  - 7: reserved, treated as HOLD.
- Boundary conditions:
  - CALL with stack_full = 1: no push, sp unchanged, q unchanged (jump suppressed), stack_err <= 1.
  - RET with stack_empty = 1: sp unchanged, q unchanged, stack_err <= 1.
  - stack_err is sticky; it is cleared only by reset.
- Flags are decoded from the registered sp and change in the same cycle as sp:
  - stack_empty = (sp == 0)
  - stack_full = (sp == DEPTH)
- sp width is clog2(DEPTH+1).
- Reset asserted in the same cycle as CALL or RET: reset wins; no push or pop occurs.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined: sel = 6 performs q <= q + sign_extend(d), modulo 2^WIDTH. d is treated as a two's-complement WIDTH-bit offset. The stack is untouched.
- Not defined: sel = 6 behaves as HOLD and no adder is instantiated.

Decomposition:
- Shared package neander_pkg holds the PC mode localparams: PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_VEC, PC_REL.
- One sub-module, pc_ret_stack, is natural. It is a DEPTH x WIDTH LIFO with push, pop, push data, top data, sp, empty and full, plus internal overflow/underflow guards.
- The top level contains the next-PC mux, incrementer, PC register and error flag.

Test Plan:
- Reset then INC x3 (WIDTH=8) -> q = 0,1,2,3 on successive cycles; with q = 0xFF, INC -> q = 0x00, stack_err = 0.
- LOAD with d = 0x80, then en = 0 with sel = INC for 2 cycles -> q = 0x80 held; en = 1, INC -> q = 0x81.
- q = 0x10: CALL d = 0x40, CALL d = 0x60 -> q = 0x60, sp = 2; RET -> q = 0x41; RET -> q = 0x11; stack_empty = 1.
- DEPTH=4: 4 CALLs -> stack_full = 1; 5th CALL d = 0xAA -> q unchanged, stack_err = 1; further RETs return the correct 4 addresses and stack_err stays 1.
- From reset, RET -> q = RESET_VEC, stack_err = 1; then reset -> stack_err = 0.
- With PC_REL_BRANCH_EN defined: q = 0x20, REL d = 0xFE -> q = 0x1E; REL d = 0x05 -> q = 0x23. Without the macro: REL -> q unchanged.
